sram_arbiter: RTL

- Shares the single external-SRAM controller (sram) between two requesters:
  - video line fetch (read-only, latency-critical, fed from vga timing);
  - draw port (read/write, fed by the camera/pen pipeline).
- Sits between these requesters and sram in top.
- Sequences exactly one SRAM transaction at a time.
- Applies fixed video priority, with an anti-starvation grant for the draw port.

---
 rtl/sram_pkg.sv | 26 ++
 rtl/sram_arb_pick.sv | 54 +++++
 rtl/sram_arbiter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// ----------------------------------------------------------------------------
// sram_pkg
// Types and widths shared by the SRAM arbiter and its grant picker.
//   ADDR_W / DATA_W : default SRAM word-address and data widths
//   state_t         : arbiter transaction FSM encoding
//   owner_t         : which requester owns the transaction in flight
// ----------------------------------------------------------------------------
package sram_pkg;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_DRW  = 2'd2
    } owner_t;

endpackage

// File: rtl/sram_arb_pick.sv
// ----------------------------------------------------------------------------
// sram_arb_pick
// Fixed video priority with an anti-starvation turn for the draw port. The
// streak counter counts video grants made while draw was waiting; once it
// reaches MAX_VID_STREAK, the next contended grant goes to draw.
//
// Ports
//   clk, reset    : clock, asynchronous active-high reset
//   i_arb_en      : high while the arbiter is in IDLE and may grant
//   i_vid_req     : video request level
//   i_drw_req     : draw request level
//   o_grant_vid   : video wins this cycle (combinational)
//   o_grant_drw   : draw wins this cycle (combinational)
// ----------------------------------------------------------------------------
module sram_arb_pick #(
    parameter int MAX_VID_STREAK = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic i_arb_en,
    input  logic i_vid_req,
    input  logic i_drw_req,
    output logic o_grant_vid,
    output logic o_grant_drw
);

    localparam int STREAK_W = (MAX_VID_STREAK < 1) ? 1 : $clog2(MAX_VID_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_VID_STREAK);

    logic [STREAK_W-1:0] r_streak;
    logic                w_draw_turn;

    assign w_draw_turn = (r_streak == STREAK_MAX);

    assign o_grant_vid = i_arb_en & i_vid_req & (~i_drw_req | ~w_draw_turn);
    assign o_grant_drw = i_arb_en & i_drw_req & (~i_vid_req |  w_draw_turn);

    // NOTE: state updates use non-blocking (<=) so every flop samples the
    // pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_streak <= '0;
        end else if (o_grant_drw) begin
            r_streak <= '0;
        end else if (o_grant_vid) begin
            if (!i_drw_req) begin
                r_streak <= '0;                     // draw not waiting: no debt
            end else if (r_streak != STREAK_MAX) begin
                r_streak <= r_streak + 1'b1;        // saturating
            end
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// ----------------------------------------------------------------------------
// sram_arbiter
// Shares the single SRAM controller between the video line fetch (read-only)
// and the draw port (read/write). One transaction at a time:
//   IDLE -> ISSUE -> WAIT -> ACK -> IDLE
// The winner is latched in IDLE, the strobe pulses in ISSUE, read data is
// captured on mem_ready in WAIT and the owner's ack pulses in ACK.
//
// Optional build macro: SRAM_ARB_TIMEOUT_EN
//   Adds a WAIT watchdog of TIMEOUT cycles; on expiry the transaction is
//   acked with data 0 and the sticky err flag is set. Without the macro WAIT
//   is unbounded and err is tied to 0.
//
// Ports
//   clk, reset                         : clock, asynchronous active-high reset
//   vid_req/vid_addr -> vid_ack/vid_data : video read port
//   drw_req/drw_we/drw_addr/drw_wdata -> drw_ack/drw_rdata : draw port
//   mem_address/mem_data_write/mem_read/mem_write : to SRAM controller
//   mem_ready/mem_data_read            : from SRAM controller
//   err                                : sticky watchdog flag
// ----------------------------------------------------------------------------
module sram_arbiter #(
    parameter int ADDR_W         = sram_pkg::ADDR_W,
    parameter int DATA_W         = sram_pkg::DATA_W,
    parameter int MAX_VID_STREAK = 8
`ifdef SRAM_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT        = 15
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic [DATA_W-1:0] vid_data,
    input  logic              drw_req,
    input  logic              drw_we,
    input  logic [ADDR_W-1:0] drw_addr,
    input  logic [DATA_W-1:0] drw_wdata,
    output logic              drw_ack,
    output logic [DATA_W-1:0] drw_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_write,
    output logic              mem_read,
    output logic              mem_write,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_data_read,
    output logic              err
);

    import sram_pkg::*;

    state_t              r_state;
    state_t              w_next;
    owner_t              r_owner;
    logic                r_we;
    logic                w_grant_vid;
    logic                w_grant_drw;
    logic                w_drw_write;
    logic [DATA_W-1:0]   w_rdata;

    sram_arb_pick #(
        .MAX_VID_STREAK (MAX_VID_STREAK)
    ) u_pick (
        .clk         (clk),
        .reset       (reset),
        .i_arb_en    (r_state == IDLE),
        .i_vid_req   (vid_req),
        .i_drw_req   (drw_req),
        .o_grant_vid (w_grant_vid),
        .o_grant_drw (w_grant_drw)
    );

    assign w_drw_write = w_grant_drw & drw_we;

`ifdef SRAM_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) < 4) ? 4 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_err;
    logic             w_timeout;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // ---------------- FSM: next state ----------------
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        w_next = r_state;
`ifdef SRAM_ARB_TIMEOUT_EN
        w_timeout = 1'b0;
`endif
        case (r_state)
            IDLE:    if (w_grant_vid || w_grant_drw) w_next = ISSUE;
            ISSUE:   w_next = WAIT;
            WAIT: begin
                if (mem_ready) begin
                    w_next = ACK;
`ifdef SRAM_ARB_TIMEOUT_EN
                end else if (r_wait_cnt == CNT_LAST) begin
                    w_next    = ACK;
                    w_timeout = 1'b1;
`endif
                end
            end
            ACK:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

`ifdef SRAM_ARB_TIMEOUT_EN
    // A real completion wins over an expiry landing on the same cycle.
    assign w_rdata = w_timeout ? '0 : mem_data_read;
    assign err     = r_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            if (r_state == WAIT && w_next == WAIT) r_wait_cnt <= r_wait_cnt + 1'b1;
            else                                   r_wait_cnt <= '0;
            if (w_timeout) r_err <= 1'b1;
        end
    end
`else
    assign w_rdata = mem_data_read;
    assign err     = 1'b0;
`endif

    // ---------------- datapath and strobes ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner        <= OWN_NONE;
            r_we           <= 1'b0;
            mem_address    <= '0;
            mem_data_write <= '0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            vid_ack        <= 1'b0;
            vid_data       <= '0;
            drw_ack        <= 1'b0;
            drw_rdata      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_vid || w_grant_drw) begin
                        r_owner     <= w_grant_drw ? OWN_DRW : OWN_VID;
                        r_we        <= w_drw_write;
                        mem_address <= w_grant_drw ? drw_addr : vid_addr;
                        if (w_drw_write) mem_data_write <= drw_wdata;
                        // Strobes rise with the move to ISSUE so they are
                        // high for exactly the ISSUE cycle.
                        mem_read    <= ~w_drw_write;
                        mem_write   <=  w_drw_write;
                    end
                end
                ISSUE: begin
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                end
                WAIT: begin
                    if (w_next == ACK) begin
                        if (r_owner == OWN_VID) begin
                            vid_ack  <= 1'b1;
                            vid_data <= w_rdata;
                        end
                        if (r_owner == OWN_DRW) begin
                            drw_ack <= 1'b1;
                            if (!r_we) drw_rdata <= w_rdata;
                        end
                    end
                end
                ACK: begin
                    vid_ack <= 1'b0;
                    drw_ack <= 1'b0;
                    r_owner <= OWN_NONE;
                end
                default: ;
            endcase
        end
    end

endmodule
